// File: rtl/ebus_arb_mux.sv
// EBUS driver arbiter/mux: picks one of NDRV drivers (fixed priority or round-robin), registers its data
// and monitors the demand/xfer handshake for timeouts. Latency 1 cycle; no backpressure, data is never gated.
module ebus_arb_mux #(
    parameter int NDRV  = 32,
    parameter int WIDTH = 36,
    parameter int RR    = 0,
    parameter int TMO   = 255,
    localparam int OW   = (NDRV > 1) ? $clog2(NDRV) : 1
) (
    input  logic                        clk,
    input  logic                        crobar,
    input  logic [NDRV-1:0]             drv_driving,
    input  logic [NDRV-1:0][WIDTH-1:0]  drv_data,
    input  logic                        demand_h,
    input  logic                        xfer_h,
    input  logic                        err_clr_h,
    output logic [WIDTH-1:0]            ebus_data,
    output logic                        ebus_valid_h,
    output logic [OW-1:0]               ebus_owner,
    output logic                        contention_h,
    output logic [7:0]                  contention_cnt,
    output logic                        tmo_h,
    output logic [1:0]                  hs_state
);

    typedef enum logic [1:0] {
        HS_IDLE = 2'd0,
        HS_WAIT = 2'd1,
        HS_ACK  = 2'd2,
        HS_TMO  = 2'd3
    } hs_t;

    hs_t          state, state_nxt;
    logic [15:0]  wait_cnt;
    logic [16:0]  wait_inc;
    logic         tmo_evt;

    logic [OW-1:0] rr_ptr;
    logic [OW-1:0] win_idx;
    logic          win_vld;
    logic          contend;

    // Winner selection; round-robin search starts at rr_ptr and wraps.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        if (RR == 0) begin
            for (int i = NDRV - 1; i >= 0; i--) begin
                if (drv_driving[i]) begin
                    win_vld = 1'b1;
                    win_idx = OW'(i);
                end
            end
        end else begin
            for (int k = 0; k < NDRV; k++) begin
                int j;
                j = (int'(rr_ptr) + k) % NDRV;
                if (!win_vld && drv_driving[j]) begin
                    win_vld = 1'b1;
                    win_idx = OW'(j);
                end
            end
        end
    end

    // More than one bit set: clearing the lowest set bit leaves something.
    assign contend = |(drv_driving & (drv_driving - NDRV'(1)));

    always_ff @(posedge clk) begin
        if (crobar) begin
            ebus_data      <= '0;
            ebus_valid_h   <= 1'b0;
            ebus_owner     <= '0;
            rr_ptr         <= '0;
            contention_h   <= 1'b0;
            contention_cnt <= 8'd0;
            tmo_h          <= 1'b0;
        end else begin
            ebus_valid_h <= win_vld;
            ebus_data    <= win_vld ? drv_data[win_idx] : '0;
            if (win_vld) begin
                ebus_owner <= win_idx;
                if (RR != 0) begin
                    rr_ptr <= (int'(win_idx) == NDRV - 1) ? '0 : win_idx + OW'(1);
                end
            end
            // A new event in the same cycle as a clear wins and restarts the count at 1.
            if (contend) begin
                contention_h   <= 1'b1;
                contention_cnt <= err_clr_h ? 8'd1 :
                                  (contention_cnt == 8'd255) ? 8'd255 : contention_cnt + 8'd1;
            end else if (err_clr_h) begin
                contention_h   <= 1'b0;
                contention_cnt <= 8'd0;
            end
            if (tmo_evt) begin
                tmo_h <= 1'b1;
            end else if (err_clr_h) begin
                tmo_h <= 1'b0;
            end
        end
    end

    // Handshake FSM: state register and wait counter.
    always_ff @(posedge clk) begin
        if (crobar) begin
            state    <= HS_IDLE;
            wait_cnt <= 16'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (state == HS_WAIT) ? wait_cnt + 16'd1 : 16'd0;
        end
    end

    assign wait_inc = {1'b0, wait_cnt} + 17'd1;

    // Withdrawn demand beats xfer and timeout in WAIT; xfer beats timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            HS_IDLE: if (demand_h) state_nxt = xfer_h ? HS_ACK : HS_WAIT;
            HS_WAIT: begin
                if (!demand_h)                state_nxt = HS_IDLE;
                else if (xfer_h)              state_nxt = HS_ACK;
                else if (wait_inc == 17'(TMO)) state_nxt = HS_TMO;
            end
            HS_ACK:  if (!demand_h) state_nxt = HS_IDLE;
            HS_TMO:  if (!demand_h) state_nxt = HS_IDLE;
            default: state_nxt = HS_IDLE;
        endcase
    end

    always_comb begin
        hs_state = state;
        tmo_evt  = (state == HS_WAIT) && (state_nxt == HS_TMO);
    end

endmodule

// File: tb/tb_ebus_arb_mux.sv
// Bench for ebus_arb_mux: a fixed-priority and a round-robin instance share stimulus,
// each cycle compared against a cycle-level reference model; directed steps cover the corner cases.
module tb_ebus_arb_mux;
    localparam int N = 32;
    localparam int W = 36;

    logic                 clk = 1'b0;
    logic                 crobar;
    logic [N-1:0]         drv_driving;
    logic [N-1:0][W-1:0]  drv_data;
    logic                 demand_h, xfer_h, err_clr_h;

    logic [W-1:0] fp_data, rr_data;
    logic         fp_valid, rr_valid, fp_cont, rr_cont, fp_tmo, rr_tmo;
    logic [4:0]   fp_owner, rr_owner;
    logic [7:0]   fp_cnt, rr_cnt;
    logic [1:0]   fp_hs, rr_hs;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ebus_arb_mux #(.NDRV(N), .WIDTH(W), .RR(0), .TMO(4)) u_fp (
        .clk(clk), .crobar(crobar), .drv_driving(drv_driving), .drv_data(drv_data),
        .demand_h(demand_h), .xfer_h(xfer_h), .err_clr_h(err_clr_h),
        .ebus_data(fp_data), .ebus_valid_h(fp_valid), .ebus_owner(fp_owner),
        .contention_h(fp_cont), .contention_cnt(fp_cnt), .tmo_h(fp_tmo), .hs_state(fp_hs));

    ebus_arb_mux #(.NDRV(N), .WIDTH(W), .RR(1), .TMO(4)) u_rr (
        .clk(clk), .crobar(crobar), .drv_driving(drv_driving), .drv_data(drv_data),
        .demand_h(demand_h), .xfer_h(xfer_h), .err_clr_h(err_clr_h),
        .ebus_data(rr_data), .ebus_valid_h(rr_valid), .ebus_owner(rr_owner),
        .contention_h(rr_cont), .contention_cnt(rr_cnt), .tmo_h(rr_tmo), .hs_state(rr_hs));

    // Reference model state: index 0 = fixed priority, 1 = round robin.
    logic [W-1:0] m_data [2];
    logic         m_valid[2];
    int           m_owner[2];
    int           m_ptr, m_cnt, m_hs, m_waited;
    logic         m_cont, m_tmo;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int win[2];
        if (crobar) begin
            for (int u = 0; u < 2; u++) begin
                m_data[u] = '0; m_valid[u] = 1'b0; m_owner[u] = 0;
            end
            m_ptr = 0; m_cnt = 0; m_hs = 0; m_waited = 0; m_cont = 1'b0; m_tmo = 1'b0;
            return;
        end
        win[0] = -1;
        win[1] = -1;
        for (int i = 0; i < N; i++) begin
            if (drv_driving[i]) begin
                win[0] = i;
                break;
            end
        end
        for (int k = 0; k < N; k++) begin
            if (drv_driving[(m_ptr + k) % N]) begin
                win[1] = (m_ptr + k) % N;
                break;
            end
        end
        for (int u = 0; u < 2; u++) begin
            m_valid[u] = (win[u] >= 0);
            m_data[u]  = (win[u] >= 0) ? drv_data[win[u]] : '0;
            if (win[u] >= 0) m_owner[u] = win[u];
        end
        if (win[1] >= 0) m_ptr = (win[1] + 1) % N;
        if ($countones(drv_driving) > 1) begin
            m_cont = 1'b1;
            m_cnt  = err_clr_h ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
        end else if (err_clr_h) begin
            m_cont = 1'b0;
            m_cnt  = 0;
        end
        // Handshake: timeout after TMO(=4) consecutive cycles spent waiting.
        if (m_hs == 0) begin
            if (demand_h) begin m_hs = xfer_h ? 2 : 1; m_waited = 0; end
            if (err_clr_h) m_tmo = 1'b0;
        end else if (m_hs == 1) begin
            m_waited++;
            if (!demand_h)           m_hs = 0;
            else if (xfer_h)         m_hs = 2;
            else if (m_waited == 4)  m_hs = 3;
            if (m_hs == 3)           m_tmo = 1'b1;
            else if (err_clr_h)      m_tmo = 1'b0;
        end else begin
            if (!demand_h) m_hs = 0;
            if (err_clr_h) m_tmo = 1'b0;
        end
    endtask

    task automatic check_all();
        chk("fp_data",  64'(fp_data),  64'(m_data[0]));
        chk("fp_valid", 64'(fp_valid), 64'(m_valid[0]));
        chk("fp_owner", 64'(fp_owner), 64'(m_owner[0]));
        chk("rr_data",  64'(rr_data),  64'(m_data[1]));
        chk("rr_valid", 64'(rr_valid), 64'(m_valid[1]));
        chk("rr_owner", 64'(rr_owner), 64'(m_owner[1]));
        chk("fp_cont",  64'(fp_cont),  64'(m_cont));
        chk("rr_cont",  64'(rr_cont),  64'(m_cont));
        chk("fp_cnt",   64'(fp_cnt),   64'(m_cnt));
        chk("rr_cnt",   64'(rr_cnt),   64'(m_cnt));
        chk("fp_tmo",   64'(fp_tmo),   64'(m_tmo));
        chk("fp_hs",    64'(fp_hs),    64'(m_hs));
        chk("rr_hs",    64'(rr_hs),    64'(m_hs));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        crobar = 1'b0; drv_driving = '0; demand_h = 1'b0; xfer_h = 1'b0; err_clr_h = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) drv_data[i] = W'({$urandom, $urandom});
        idle_inputs();
        crobar = 1'b1; drv_driving = '1; demand_h = 1'b1; err_clr_h = 1'b1;
        cycle();
        chk("rst_valid", 64'(fp_valid), 64'd0);
        chk("rst_owner", 64'(rr_owner), 64'd0);
        chk("rst_hs",    64'(fp_hs),    64'd0);

        // Fixed priority with two drivers contending.
        idle_inputs();
        drv_driving = '0; drv_driving[5] = 1'b1; drv_driving[9] = 1'b1;
        drv_data[5] = 36'o123; drv_data[9] = 36'o777;
        cycle();
        chk("fp_req_data",  64'(fp_data),  64'o123);
        chk("fp_req_owner", 64'(fp_owner), 64'd5);
        chk("fp_req_cont",  64'(fp_cont),  64'd1);
        chk("fp_req_cnt",   64'(fp_cnt),   64'd1);

        // Round robin alternation after reset.
        crobar = 1'b1; cycle(); idle_inputs();
        drv_driving[2] = 1'b1; drv_driving[7] = 1'b1;
        cycle(); chk("rr_own0", 64'(rr_owner), 64'd2);
        cycle(); chk("rr_own1", 64'(rr_owner), 64'd7);
        cycle(); chk("rr_own2", 64'(rr_owner), 64'd2);
        cycle(); chk("rr_own3", 64'(rr_owner), 64'd7);
        chk("rr_cnt4", 64'(rr_cnt), 64'd4);

        // Clear and new contention in the same cycle: event wins.
        err_clr_h = 1'b1;
        cycle(); chk("clr_evt_cnt", 64'(fp_cnt), 64'd1);
        chk("clr_evt_flag", 64'(fp_cont), 64'd1);

        // Timeout after four WAIT cycles; flag sticks after demand drops.
        crobar = 1'b1; cycle(); idle_inputs();
        demand_h = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cycle(); chk("tmo_wait", 64'(fp_hs), 64'd1);
        end
        cycle(); chk("tmo_state", 64'(fp_hs), 64'd3);
        chk("tmo_flag", 64'(fp_tmo), 64'd1);
        demand_h = 1'b0;
        cycle(); chk("tmo_idle", 64'(fp_hs), 64'd0);
        chk("tmo_sticky", 64'(fp_tmo), 64'd1);

        // xfer arriving exactly at the timeout point wins.
        crobar = 1'b1; cycle(); idle_inputs();
        demand_h = 1'b1;
        for (int c = 0; c < 4; c++) cycle();
        xfer_h = 1'b1;
        cycle(); chk("race_state", 64'(fp_hs), 64'd2);
        chk("race_tmo", 64'(fp_tmo), 64'd0);

        // Reset during ACK with valid data, then a clean first cycle.
        drv_driving[3] = 1'b1;
        cycle(); chk("ack_valid", 64'(fp_valid), 64'd1);
        chk("ack_state", 64'(fp_hs), 64'd2);
        crobar = 1'b1; err_clr_h = 1'b1;
        cycle(); chk("mid_rst_hs", 64'(fp_hs), 64'd0);
        chk("mid_rst_valid", 64'(fp_valid), 64'd0);
        chk("mid_rst_data",  64'(fp_data),  64'd0);
        idle_inputs();
        cycle(); chk("post_rst_valid", 64'(rr_valid), 64'd0);

        // Saturation then clear.
        for (int c = 0; c < 300; c++) begin
            drv_driving = N'($urandom) | 32'h3;
            cycle();
        end
        chk("sat_cnt", 64'(fp_cnt), 64'd255);
        drv_driving = '0; err_clr_h = 1'b1;
        cycle(); chk("clr_cnt", 64'(fp_cnt), 64'd0);
        chk("clr_flag", 64'(fp_cont), 64'd0);

        // Randomized traffic against the model.
        idle_inputs();
        for (int c = 0; c < 600; c++) begin
            case ($urandom_range(0, 3))
                0: drv_driving = '0;
                1: drv_driving = N'(1) << $urandom_range(0, N - 1);
                2: drv_driving = (N'(1) << $urandom_range(0, N - 1)) | (N'(1) << $urandom_range(0, N - 1));
                default: drv_driving = N'($urandom);
            endcase
            if ($urandom_range(0, 3) == 0) drv_data[$urandom_range(0, N - 1)] = W'({$urandom, $urandom});
            if ($urandom_range(0, 7) == 0) demand_h = ~demand_h;
            xfer_h    = ($urandom_range(0, 5) == 0);
            err_clr_h = ($urandom_range(0, 15) == 0);
            crobar    = ($urandom_range(0, 63) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ebus_arb_mux.md
EBUS_ARB_MUX -- requirements
Module: ebus_arb_mux

Interface
REQ-001 Parameter NDRV, default 32: number of EBUS driver channels, range 2..64.
REQ-002 Parameter WIDTH, default 36: EBUS data width in bits.
REQ-003 Parameter RR, default 0: selects the arbitration mode; 0 = fixed priority with channel 0 highest, 1 = round-robin.
REQ-004 Parameter TMO, default 255: number of demand-to-xfer timeout cycles, range 1..65535.
REQ-005 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-006 Port crobar, input, 1: reset, synchronous and active-high.
REQ-007 Port drv_driving, input, NDRV: per-channel request to drive the EBUS.
REQ-008 Port drv_data, input, NDRV x WIDTH: per-channel data.
REQ-009 Port demand_h, input, 1: EBUS demand from the bus master.
REQ-010 Port xfer_h, input, 1: EBUS transfer acknowledge from the addressed slave.
REQ-011 Port err_clr_h, input, 1: clears the sticky error state.
REQ-012 Port ebus_data, output, WIDTH: registered EBUS data.
REQ-013 Port ebus_valid_h, output, 1: high when ebus_data holds data from a granted channel.
REQ-014 Port ebus_owner, output, clog2(NDRV): index of the granted channel.
REQ-015 Port contention_h, output, 1: sticky flag; two or more channels drove the bus in the same cycle.
REQ-016 Port contention_cnt, output, 8: saturating count of contention cycles.
REQ-017 Port tmo_h, output, 1: sticky flag; a demand timed out without xfer.
REQ-018 Port hs_state, output, 2: current handshake FSM state.

Function
REQ-019 Channel selection in fixed-priority mode (RR=0): the lowest-index channel with drv_driving asserted wins.
REQ-020 Channel selection in round-robin mode (RR=1):
- search starts at rr_ptr and wraps from NDRV-1 to 0;
- after any cycle in which a grant is issued, rr_ptr becomes (winner+1) mod NDRV;
- when there is no grant, rr_ptr holds.
REQ-021 Output latency is one cycle: ebus_data, ebus_owner and ebus_valid_h register the winner selected in cycle N and present it in cycle N+1.
REQ-022 When no channel is driving, the block SHALL:
- register ebus_data = 0 and ebus_valid_h = 0;
- hold ebus_owner at its previous value.
REQ-023 Contention handling:
- more than one drv_driving bit in a cycle sets contention_h and increments contention_cnt, saturating at 255;
- the winner is still driven per REQ-019/REQ-020.
REQ-024 Handshake FSM has states IDLE=0, WAIT=1, ACK=2, TMO=3, with these transitions:
- IDLE to WAIT on demand_h=1 with xfer_h=0;
- IDLE to ACK on demand_h=1 with xfer_h=1;
- WAIT to ACK on xfer_h=1;
- WAIT to TMO when the wait counter reaches TMO;
- ACK to IDLE on demand_h=0;
- TMO to IDLE on demand_h=0;
- WAIT to IDLE on demand_h=0 (demand withdrawn), with no error.
REQ-025 Wait counter behaviour:
- loads 0 on entry to WAIT and increments each cycle in WAIT;
- if xfer_h and the count reaching TMO occur in the same cycle, xfer_h wins and the next state is ACK.
REQ-026 Entry to TMO sets tmo_h.
REQ-027 Error clearing:
- err_clr_h clears contention_h, contention_cnt and tmo_h;
- if a new error event occurs in the same cycle, the event wins: the flag is set and the count becomes 1.
REQ-028 Data selection is independent of FSM state; the FSM only monitors the handshake and does not gate data.

Reset
REQ-029 When crobar=1 at a clock edge, the block SHALL set all of the following:
- ebus_data=0, ebus_valid_h=0, ebus_owner=0;
- rr_ptr=0, hs_state=IDLE, wait counter=0;
- contention_h=0, contention_cnt=0, tmo_h=0.
REQ-030 Reset overrides all inputs, including reset asserted mid-handshake (WAIT or ACK) and the same-cycle err_clr_h.
REQ-031 The first cycle after reset deasserts SHALL behave as a fresh IDLE cycle, with no stale grant.

Verification
REQ-032 Fixed-priority mode (RR=0), NDRV=32:
- stimulus: drv_driving bits 5 and 9 set, with drv_data[5]=0o123 and drv_data[9]=0o777;
- required response next cycle: ebus_data=0o123, ebus_owner=5, contention_h=1, contention_cnt=1.
REQ-033 Round-robin mode (RR=1):
- stimulus: channels 2 and 7 both driving continuously for 4 cycles;
- required response: owners 2,7,2,7, and contention_cnt=4.
REQ-034 Timeout:
- stimulus: TMO=4, demand_h held high with xfer_h=0;
- required response: hs_state goes 1,1,1,1 then 3, and tmo_h=1;
- then drop demand_h: hs_state=0 and tmo_h stays 1.
REQ-035 Simultaneous event at timeout:
- stimulus: xfer_h asserted in the same cycle the wait counter reaches TMO;
- required response: hs_state=2 and tmo_h=0.
REQ-036 Saturation and clear:
- stimulus: 300 consecutive contention cycles;
- required response: contention_cnt=255;
- then err_clr_h=1 with no driver active: contention_cnt=0 and contention_h=0.
REQ-037 Reset mid-handshake:
- stimulus: crobar pulsed while hs_state=ACK and ebus_valid_h=1;
- required response next cycle: hs_state=0, ebus_valid_h=0, ebus_data=0.
